// File: rtl/pong_referee.sv
// pong_referee: game-control sequencer that scores points, re-serves the ball and ends the game (macro PONG_WIN_BY_TWO_EN selects the win-by-two end rule)
module pong_referee #(
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic [1:0]         win,
   output logic               ball_rst,
   output logic               pause,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic               game_over,
   output logic [1:0]         winner
);
   typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [15:0] LAST_TICK = 16'(SERVE_TICKS - 1);
   state_t state, state_next;
   logic start_q, pause_q, start_edge, pause_edge;
   logic paused, paused_next;
   logic [15:0] serve_cnt, serve_cnt_next;
   logic scorer;
   logic [SCORE_W-1:0] credited;
   logic game_end, inc0, inc1, clear;
`ifdef PONG_WIN_BY_TWO_EN
   logic [SCORE_W-1:0] other;
   logic [SCORE_W+1:0] other_plus2;
`endif
   assign start_edge = start_btn & ~start_q;
   assign pause_edge = pause_btn & ~pause_q;
   assign ball_rst = state != PLAY;
   assign pause = paused & (state == PLAY);
   // end-of-game test on the scores already updated by the point just taken
   always_comb begin
      credited = scorer ? score1 : score0;
`ifdef PONG_WIN_BY_TWO_EN
      other = scorer ? score0 : score1;
      other_plus2 = {2'b00, other} + (SCORE_W+2)'(2);
      game_end = ({2'b00, credited} >= (SCORE_W+2)'(WIN_SCORE) && {2'b00, credited} >= other_plus2) || credited == SCORE_MAX;
`else
      game_end = credited == SCORE_W'(WIN_SCORE) || credited == SCORE_MAX;
`endif
   end
   // next-state, serve counter, paused flag and score strobes
   always_comb begin
      state_next = state;
      serve_cnt_next = serve_cnt;
      paused_next = paused;
      inc0 = 1'b0;
      inc1 = 1'b0;
      clear = 1'b0;
      case (state)
         IDLE: state_next = start_edge ? SERVE : IDLE;
         SERVE: if (tick) begin
            serve_cnt_next = serve_cnt == LAST_TICK ? 16'd0 : serve_cnt + 16'd1;
            state_next = serve_cnt == LAST_TICK ? PLAY : SERVE;
         end
         PLAY: if (win != 2'b00) begin
            state_next = POINT;
            paused_next = 1'b0;
            inc1 = win[1];
            inc0 = ~win[1];
         end else if (pause_edge) begin
            paused_next = ~paused;
         end
         POINT: begin
            state_next = game_end ? OVER : SERVE;
            paused_next = 1'b0;
         end
         OVER: if (start_edge) begin
            state_next = SERVE;
            clear = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end
   // state register, serve counter, paused flag and button edge detectors
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         serve_cnt <= 16'd0;
         paused <= 1'b0;
         start_q <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state <= state_next;
         serve_cnt <= serve_cnt_next;
         paused <= paused_next;
         start_q <= start_btn;
         pause_q <= pause_btn;
      end
   end
   // saturating scores, last scorer, game_over and winner registers
   always_ff @(posedge clk) begin
      if (rst) begin
         score0 <= '0;
         score1 <= '0;
         scorer <= 1'b0;
         game_over <= 1'b0;
         winner <= 2'b00;
      end else begin
         if (clear) score0 <= '0;
         else if (inc0 && score0 != SCORE_MAX) score0 <= score0 + 1'b1;
         if (clear) score1 <= '0;
         else if (inc1 && score1 != SCORE_MAX) score1 <= score1 + 1'b1;
         if (inc0 | inc1) scorer <= inc1;
         game_over <= state_next == OVER;
         if (clear) winner <= 2'b00;
         else if (state == POINT && game_end) winner <= scorer ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: tb/tb_pong_referee.sv
// tb_pong_referee: directed test-plan steps plus random play against a rule-level referee model
module tb_pong_referee;
   localparam int SW = 4;
   localparam int WS = 7;
   localparam int ST = 3;
   localparam int SMAX = (1 << SW) - 1;
   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
   logic clk = 1'b0, rst = 1'b0, tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
   logic [1:0] win = 2'b00;
   logic ball_rst, pause, game_over;
   logic [SW-1:0] score0, score1;
   logic [1:0] winner;
   int total = 0, bad = 0;
   int m_mode = M_IDLE, m_left = 0, m_who = 0, m_win = 0;
   int m_sc[2] = '{0, 0};
   bit m_paused = 0, m_over = 0, m_ps = 0, m_pp = 0;
   pong_referee #(.SCORE_W(SW), .WIN_SCORE(WS), .SERVE_TICKS(ST)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn), .pause_btn(pause_btn),
      .win(win), .ball_rst(ball_rst), .pause(pause), .score0(score0), .score1(score1),
      .game_over(game_over), .winner(winner)
   );
   always #5 clk = ~clk;
   function automatic bit ends(input int who);
      int c = m_sc[who];
`ifdef PONG_WIN_BY_TWO_EN
      return (c >= WS && c >= m_sc[1-who] + 2) || c == SMAX;
`else
      return c == WS || c == SMAX;
`endif
   endfunction
   task automatic model(input bit r, input bit s, input bit p, input bit t, input logic [1:0] w);
      bit se, pe;
      if (r) begin
         m_mode = M_IDLE; m_left = 0; m_sc = '{0, 0}; m_paused = 0; m_over = 0; m_win = 0; m_ps = 0; m_pp = 0;
      end else begin
         se = s && !m_ps;
         pe = p && !m_pp;
         m_ps = s;
         m_pp = p;
         case (m_mode)
            M_IDLE: if (se) begin m_mode = M_SERVE; m_left = ST; end
            M_SERVE: if (t) begin m_left--; if (m_left == 0) m_mode = M_PLAY; end
            M_PLAY: if (w != 0) begin
               m_who = w[1] ? 1 : 0;
               if (m_sc[m_who] < SMAX) m_sc[m_who]++;
               m_paused = 0;
               m_mode = M_POINT;
            end else if (pe) m_paused = !m_paused;
            M_POINT: if (ends(m_who)) begin
               m_mode = M_OVER; m_over = 1; m_win = m_who ? 2 : 1;
            end else begin
               m_mode = M_SERVE; m_left = ST;
            end
            M_OVER: if (se) begin
               m_sc = '{0, 0}; m_win = 0; m_over = 0; m_mode = M_SERVE; m_left = ST;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input bit r, input bit s, input bit p, input bit t, input logic [1:0] w);
      rst = r; start_btn = s; pause_btn = p; tick = t; win = w;
      @(posedge clk);
      model(r, s, p, t, w);
      #1;
      chk("m_ball_rst", 32'(ball_rst), 32'(m_mode != M_PLAY));
      chk("m_pause", 32'(pause), 32'(m_paused && m_mode == M_PLAY));
      chk("m_score0", 32'(score0), 32'(m_sc[0]));
      chk("m_score1", 32'(score1), 32'(m_sc[1]));
      chk("m_game_over", 32'(game_over), 32'(m_over));
      chk("m_winner", 32'(winner), 32'(m_win));
   endtask
   task automatic serve();
      repeat (ST) cyc(0, 0, 0, 1, 2'b00);
   endtask
   task automatic point(input logic [1:0] w);
      cyc(0, 0, 0, 0, w);
      cyc(0, 0, 0, 0, 2'b00);
   endtask
   initial begin
      cyc(1, 0, 0, 0, 2'b00);
      cyc(1, 0, 0, 0, 2'b00);
      chk("rst_ball_rst", 32'(ball_rst), 1);
      chk("rst_pause", 32'(pause), 0);
      chk("rst_scores", 32'({score1, score0}), 0);
      chk("rst_game_over", 32'(game_over), 0);
      chk("rst_winner", 32'(winner), 0);
      cyc(0, 1, 0, 0, 2'b00);
      chk("serve_ball_rst", 32'(ball_rst), 1);
      cyc(0, 0, 0, 1, 2'b00);
      cyc(0, 0, 0, 1, 2'b00);
      chk("tick2_ball_rst", 32'(ball_rst), 1);
      cyc(0, 0, 0, 1, 2'b00);
      chk("play_ball_rst", 32'(ball_rst), 0);
      chk("play_scores", 32'({score1, score0}), 0);
      cyc(0, 0, 0, 0, 2'b10);
      chk("point_ball_rst", 32'(ball_rst), 1);
      chk("point_score1", 32'(score1), 1);
      cyc(0, 0, 0, 0, 2'b10);
      chk("after_point_over", 32'(game_over), 0);
      repeat (3) cyc(0, 0, 0, 0, 2'b10);
      chk("held_win_score1", 32'(score1), 1);
      chk("held_win_score0", 32'(score0), 0);
      serve();
      chk("replay_ball_rst", 32'(ball_rst), 0);
      cyc(0, 0, 1, 0, 2'b00);
      chk("pause_on", 32'(pause), 1);
      cyc(0, 0, 0, 0, 2'b00);
      chk("pause_hold", 32'(pause), 1);
      cyc(0, 0, 1, 0, 2'b00);
      chk("pause_off", 32'(pause), 0);
      cyc(0, 0, 0, 0, 2'b00);
      cyc(0, 0, 1, 0, 2'b00);
      chk("pause_on2", 32'(pause), 1);
      cyc(0, 0, 0, 0, 2'b00);
      cyc(0, 0, 1, 0, 2'b01);
      chk("paused_win_score0", 32'(score0), 1);
      chk("paused_win_pause", 32'(pause), 0);
      cyc(0, 0, 0, 0, 2'b00);
      serve();
      chk("unpaused_after_point", 32'(pause), 0);
      for (int i = 0; i < 6; i++) begin
         point(2'b01);
         if (i < 5) serve();
      end
      chk("over_game_over", 32'(game_over), 1);
      chk("over_winner", 32'(winner), 2'b01);
      chk("over_score0", 32'(score0), 7);
      cyc(0, 1, 0, 0, 2'b00);
      chk("restart_scores", 32'({score1, score0}), 0);
      chk("restart_game_over", 32'(game_over), 0);
      chk("restart_winner", 32'(winner), 0);
      chk("restart_ball_rst", 32'(ball_rst), 1);
      cyc(0, 0, 0, 0, 2'b00);
      for (int i = 0; i < 12; i++) begin
         serve();
         point(i[0] ? 2'b10 : 2'b01);
      end
      chk("tied_scores", 32'({score1, score0}), 32'h66);
      serve();
      point(2'b11);
      chk("both_bits_score1", 32'(score1), 7);
      chk("both_bits_score0", 32'(score0), 6);
`ifdef PONG_WIN_BY_TWO_EN
      chk("by_two_no_end", 32'(game_over), 0);
      serve();
      point(2'b10);
      chk("by_two_score1", 32'(score1), 8);
`endif
      chk("p1_game_over", 32'(game_over), 1);
      chk("p1_winner", 32'(winner), 2'b10);
      cyc(0, 1, 0, 0, 2'b00);
      cyc(0, 0, 0, 0, 2'b00);
      for (int i = 0; i < 5; i++) begin
         serve();
         point(i[0] ? 2'b10 : 2'b01);
      end
      cyc(0, 0, 0, 1, 2'b00);
      chk("mid_serve_scores", 32'({score1, score0}), 32'h23);
      cyc(1, 0, 0, 0, 2'b00);
      chk("midrst_scores", 32'({score1, score0}), 0);
      chk("midrst_ball_rst", 32'(ball_rst), 1);
      chk("midrst_pause", 32'(pause), 0);
      chk("midrst_game_over", 32'(game_over), 0);
      cyc(0, 1, 0, 0, 2'b00);
      cyc(0, 0, 0, 1, 2'b00);
      cyc(0, 0, 0, 1, 2'b00);
      chk("midrst_cnt_tick2", 32'(ball_rst), 1);
      cyc(0, 0, 0, 1, 2'b00);
      chk("midrst_cnt_tick3", 32'(ball_rst), 0);
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pong_referee.md
# pong_referee

Game-control sequencer for the pong datapath. Consumes the ball block's `win[1:0]` point indication and drives that block's reset and `pause` inputs: scores each point exactly once, re-centres the ball, holds it for a serve delay, and ends the game at a target score. It sits between the user buttons and the ball/paddle logic, above the per-frame datapath.

## Interface
- `SCORE_W`, 4: width of each score counter.
- `WIN_SCORE`, 7: points needed to win; legal range 1..2^SCORE_W-1.
- `SERVE_TICKS`, 60: `tick` pulses the ball is held at centre before play resumes; legal range 1..65535.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle frame strobe that paces the serve delay.
- `start_btn` in 1: start/restart button, already synchronised; acts on its rising edge.
- `pause_btn` in 1: pause button, already synchronised; acts on its rising edge.
- `win` in 2: point indication from the ball block. `win[1]` credits player 1; `win[0]` credits player 0.
- `ball_rst` out 1: reset to the ball block.
- `pause` out 1: freeze to the ball block.
- `score0`, `score1` out SCORE_W: running scores.
- `game_over` out 1: high while in OVER.
- `winner` out 2: one-hot game winner, `2'b10` = player 1, `2'b01` = player 0; `0` while no game has been won.

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER. Reset enters IDLE.
- Reset values: scores 0, `game_over` 0, `winner` 0, `pause` 0, `ball_rst` 1, paused flag 0, serve counter 0.
- `ball_rst` is 1 in every state except PLAY; it is decoded from the state register.
- `pause` = paused flag AND (state == PLAY).
- Rising edges of both buttons are detected with one register stage each; the edge-detect registers reset to 0.

State transitions:
- IDLE: a `start_btn` edge goes to SERVE.
- SERVE: the 16-bit serve counter increments on each `tick`. When `tick` arrives with counter == SERVE_TICKS-1, go to PLAY and clear the counter. `win` is ignored in SERVE.
- PLAY:
  - A `pause_btn` edge toggles the paused flag.
  - `win != 0` goes to POINT and increments the credited score.
  - If both `win` bits are set, only `win[1]` scores.
  - A point takes priority over a same-cycle `pause_btn` edge. The flag is cleared and the edge is dropped.
  - `win` is honoured whether or not play is paused.
- POINT: lasts exactly one cycle. It evaluates the end condition on the updated scores, then goes to OVER if the condition holds, otherwise to SERVE. The paused flag is 0 on leaving.
- OVER: `game_over` = 1 and `winner` holds. A `start_btn` edge clears scores, `winner` and `game_over`, then goes to SERVE.
- `start_btn` is ignored in SERVE, PLAY and POINT.
- End condition (default build): the credited score equals WIN_SCORE.
- Scores never wrap. The end condition is always true at 2^SCORE_W-1.

## Timing
- A `win` bit sampled high in PLAY at edge n gives: state POINT, incremented score and `ball_rst` = 1 from cycle n+1; SERVE or OVER from n+2.
- `ball_rst` stays high for at least SERVE_TICKS `tick` periods. This outlasts the ball block's 2-cycle `win` pipeline, so a stale `win` can never double-score.
- Score, `game_over` and `winner` are registered.
- A `pause_btn` edge at edge n changes `pause` at n+1.
- A `rst` mid-game forces IDLE and all reset values on the next edge.

## Configuration
- `PONG_WIN_BY_TWO_EN`, defined: the end condition becomes credited score ≥ WIN_SCORE AND credited score ≥ other score + 2, OR credited score == 2^SCORE_W-1 (saturation stop).
- Undefined: the end condition is credited score == WIN_SCORE.

## Test plan
- Reset, start edge, then SERVE_TICKS=3 `tick` pulses -> `ball_rst` 1 through the third tick, 0 on the next cycle; state PLAY; scores 0/0.
- In PLAY, `win`=2'b10 held for 5 cycles -> `score1` = 1 exactly; POINT one cycle after the first sample; SERVE after that; `ball_rst` 1 from cycle n+1.
- `pause_btn` edge in PLAY -> `pause` 1 next cycle. Second edge -> `pause` 0. `win`=2'b01 while paused -> `score0` +1 and `pause` 0.
- Default build, WIN_SCORE=7, player 0 scores 7 -> OVER, `game_over` 1, `winner` 2'b01. A start edge -> scores 0/0 and SERVE.
- `PONG_WIN_BY_TWO_EN` defined, scores 6/6, player 1 scores -> 7/6 no end. Player 1 scores again -> 8/6, OVER, `winner` 2'b10.
- `rst` asserted during SERVE with scores 3/2 -> next cycle IDLE, scores 0/0, `ball_rst` 1, `pause` 0, serve counter 0.
